// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: arbitrates add/sub requests from two requesters onto the
// shared FP add datapath, unpacks operands for the preadder, waits a fixed
// datapath latency, then returns the captured result through valid/ready.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready            request handshake, N = 0,1 (ready is combinational)
//   reqN_sub, reqN_a, reqN_b    operation (1 = A-B) and packed operands
//   reqN_tag                    opaque tag returned with the result
//   dp_start                    strobe in the first cycle new operands are driven
//   dp_sign_*, dp_exp_*, dp_mantis_*  unpacked operands for the preadder
//   dp_result, dp_loss          datapath result and preadder loss flag
//   res_valid/ready             result handshake
//   res_data, res_src, res_tag, res_inexact  returned result fields
//   busy                        controller is not idle
module fp_add_scheduler #(
  parameter int unsigned EXP_SIZE    = 8,
  parameter int unsigned MANTIS_SIZE = 23,
  parameter int unsigned DP_LATENCY  = 2,
  parameter int unsigned TAG_WIDTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req0_valid,
  output logic                              req0_ready,
  input  logic                              req0_sub,
  input  logic [EXP_SIZE+MANTIS_SIZE:0]     req0_a,
  input  logic [EXP_SIZE+MANTIS_SIZE:0]     req0_b,
  input  logic [TAG_WIDTH-1:0]              req0_tag,
  input  logic                              req1_valid,
  output logic                              req1_ready,
  input  logic                              req1_sub,
  input  logic [EXP_SIZE+MANTIS_SIZE:0]     req1_a,
  input  logic [EXP_SIZE+MANTIS_SIZE:0]     req1_b,
  input  logic [TAG_WIDTH-1:0]              req1_tag,
  output logic                              dp_start,
  output logic                              dp_sign_A,
  output logic                              dp_sign_B,
  output logic [EXP_SIZE-1:0]               dp_exp_A,
  output logic [EXP_SIZE-1:0]               dp_exp_B,
  output logic [MANTIS_SIZE+2:0]            dp_mantis_A,
  output logic [MANTIS_SIZE+2:0]            dp_mantis_B,
  input  logic [EXP_SIZE+MANTIS_SIZE:0]     dp_result,
  input  logic                              dp_loss,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [EXP_SIZE+MANTIS_SIZE:0]     res_data,
  output logic                              res_src,
  output logic [TAG_WIDTH-1:0]              res_tag,
  output logic                              res_inexact,
  output logic                              busy
);

  localparam int unsigned W     = 1 + EXP_SIZE + MANTIS_SIZE;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_grant_q;

  logic             grant;
  logic             accept;
  logic             capture;
  logic             sel_sub;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic [TAG_WIDTH-1:0] sel_tag;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = ISSUE;
      ISSUE:   if (capture)   state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Arbitration, request handshake and operand selection
  always_comb begin
    // Tie goes to whichever requester was not granted last
    grant = ~last_grant_q;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end

    req0_ready = 1'b0;
    req1_ready = 1'b0;
    // Gated by rst_n so ready stays low while reset is asserted
    if (rst_n && (state_q == IDLE)) begin
      req0_ready = req0_valid & ~grant;
      req1_ready = req1_valid &  grant;
    end
    accept = req0_ready | req1_ready;

    // A counter at or below 1 also ends ISSUE so the state can never stall
    capture = (state_q == ISSUE) && (cnt_q <= CNT_W'(1));

    sel_sub = grant ? req1_sub : req0_sub;
    sel_a   = grant ? req1_a   : req0_a;
    sel_b   = grant ? req1_b   : req0_b;
    sel_tag = grant ? req1_tag : req0_tag;
  end

  // Operand unpacking, latency counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      dp_start     <= 1'b0;
      dp_sign_A    <= 1'b0;
      dp_sign_B    <= 1'b0;
      dp_exp_A     <= '0;
      dp_exp_B     <= '0;
      dp_mantis_A  <= '0;
      dp_mantis_B  <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_src      <= 1'b0;
      res_tag      <= '0;
      res_inexact  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      dp_start  <= accept;
      res_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);

      if (accept) begin
        last_grant_q <= grant;
        cnt_q        <= CNT_W'(DP_LATENCY);
        dp_sign_A    <= sel_a[W-1];
        dp_sign_B    <= sel_b[W-1] ^ sel_sub;
        dp_exp_A     <= sel_a[W-2 -: EXP_SIZE];
        dp_exp_B     <= sel_b[W-2 -: EXP_SIZE];
        // Hidden bit is set for any non-zero exponent, so zero/denormal get 0
        dp_mantis_A  <= {|sel_a[W-2 -: EXP_SIZE], sel_a[MANTIS_SIZE-1:0], 2'b00};
        dp_mantis_B  <= {|sel_b[W-2 -: EXP_SIZE], sel_b[MANTIS_SIZE-1:0], 2'b00};
        res_src      <= grant;
        res_tag      <= sel_tag;
      end else if (state_q == ISSUE) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (capture) begin
        res_data    <= dp_result;
        res_inexact <= dp_loss;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Testbench for fp_add_scheduler: directed vector table, tie/backpressure/reset
// sequences and randomized traffic against a cycle-level transaction model.
module tb_fp_add_scheduler;

  localparam int unsigned EW = 8;
  localparam int unsigned MS = 23;
  localparam int unsigned L  = 2;
  localparam int unsigned TW = 4;
  localparam int unsigned W  = 1 + EW + MS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_sub;
  logic [W-1:0]  req0_a, req0_b;
  logic [TW-1:0] req0_tag;
  logic          req1_valid, req1_ready, req1_sub;
  logic [W-1:0]  req1_a, req1_b;
  logic [TW-1:0] req1_tag;
  logic          dp_start, dp_sign_A, dp_sign_B;
  logic [EW-1:0] dp_exp_A, dp_exp_B;
  logic [MS+2:0] dp_mantis_A, dp_mantis_B;
  logic [W-1:0]  dp_result;
  logic          dp_loss;
  logic          res_valid, res_ready;
  logic [W-1:0]  res_data;
  logic          res_src;
  logic [TW-1:0] res_tag;
  logic          res_inexact, busy;

  always #5 clk = ~clk;

  fp_add_scheduler #(
    .EXP_SIZE(EW), .MANTIS_SIZE(MS), .DP_LATENCY(L), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sub(req0_sub),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sub(req1_sub),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .dp_start(dp_start), .dp_sign_A(dp_sign_A), .dp_sign_B(dp_sign_B),
    .dp_exp_A(dp_exp_A), .dp_exp_B(dp_exp_B),
    .dp_mantis_A(dp_mantis_A), .dp_mantis_B(dp_mantis_B),
    .dp_result(dp_result), .dp_loss(dp_loss),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .res_tag(res_tag), .res_inexact(res_inexact),
    .busy(busy)
  );

  typedef struct {
    bit            src;
    logic [W-1:0]  a, b;
    bit            sub;
    logic [TW-1:0] tag;
    logic [W-1:0]  dres;
    bit            dloss;
    bit            sa, sb;
    logic [EW-1:0] ea, eb;
    logic [MS+2:0] ma, mb;
  } vec_t;

  typedef struct {
    bit            src;
    logic [W-1:0]  a, b;
    bit            sub;
    logic [TW-1:0] tag;
    logic [W-1:0]  dres;
    bit            dloss;
  } op_t;

  int checks = 0;
  int errors = 0;

  // Transaction model state
  int            cyc = 0;
  bit            active;
  int            acc;
  bit            last_g;
  bit            have_op;
  op_t           cur;
  bit            pend[2];
  logic [W-1:0]  pa[2], pb[2];
  bit            psub[2];
  logic [TW-1:0] ptag[2];
  bit            rr;
  bit            rr_rand;
  int            auto_pct;
  bit            forced_en;
  logic [W-1:0]  forced_res;
  bit            forced_loss;
  int            grants[$];
  vec_t          tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [MS+2:0] mant_of(input logic [W-1:0] x);
    logic [MS+2:0] m;
    m = (MS+3)'(x[MS-1:0]) * (MS+3)'(4);
    if (x[W-2:MS] != '0) m = m + ((MS+3)'(1) << (MS+2));
    return m;
  endfunction

  task automatic check_zero();
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dp_start", 64'(dp_start), 64'd0);
    chk("rst_dp_fields", 64'({dp_sign_A, dp_sign_B, dp_exp_A, dp_exp_B}), 64'd0);
    chk("rst_dp_mantis", 64'({dp_mantis_A, dp_mantis_B}), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_fields", 64'({res_data, res_src, res_tag, res_inexact}), 64'd0);
  endtask

  // Asserts reset asynchronously, checks outputs clear without a clock edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_zero();
    active  = 1'b0;
    last_g  = 1'b1;
    have_op = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs at negedge, compare outputs, advance model
  task automatic step();
    bit g;
    bit was_active;
    bit rv_e;
    bit start_e;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      if (!pend[p] && ($urandom_range(99) < 32'(auto_pct))) begin
        pend[p] = 1'b1;
        pa[p]   = $urandom;
        pb[p]   = $urandom;
        psub[p] = 1'($urandom);
        ptag[p] = TW'($urandom);
      end
    end
    req0_valid = pend[0];
    req0_a     = pend[0] ? pa[0]   : $urandom;
    req0_b     = pend[0] ? pb[0]   : $urandom;
    req0_sub   = pend[0] ? psub[0] : 1'($urandom);
    req0_tag   = pend[0] ? ptag[0] : TW'($urandom);
    req1_valid = pend[1];
    req1_a     = pend[1] ? pa[1]   : $urandom;
    req1_b     = pend[1] ? pb[1]   : $urandom;
    req1_sub   = pend[1] ? psub[1] : 1'($urandom);
    req1_tag   = pend[1] ? ptag[1] : TW'($urandom);
    if (rr_rand) rr = ($urandom_range(3) != 0);
    res_ready = rr;
    // Result is valid only in the cycle the controller must sample it
    if (active && (cyc == acc + int'(L))) begin
      dp_result = cur.dres;
      dp_loss   = cur.dloss;
    end else begin
      dp_result = $urandom;
      dp_loss   = 1'($urandom);
    end
    #1;
    was_active = active;
    rv_e    = active && (cyc >= acc + int'(L) + 1);
    start_e = active && (cyc == acc + 1);
    if (pend[0] && pend[1]) g = !last_g;
    else                    g = pend[1];

    chk("ready0", 64'(req0_ready), 64'(!active && pend[0] && !g));
    chk("ready1", 64'(req1_ready), 64'(!active && pend[1] && g));
    chk("busy", 64'(busy), 64'(active));
    chk("dp_start", 64'(dp_start), 64'(start_e));
    chk("res_valid", 64'(res_valid), 64'(rv_e));
    if (have_op) begin
      chk("dp_signs", 64'({dp_sign_A, dp_sign_B}), 64'({cur.a[W-1], cur.b[W-1] ^ cur.sub}));
      chk("dp_exps", 64'({dp_exp_A, dp_exp_B}), 64'({cur.a[W-2:MS], cur.b[W-2:MS]}));
      chk("dp_mantis", 64'({dp_mantis_A, dp_mantis_B}), 64'({mant_of(cur.a), mant_of(cur.b)}));
    end else begin
      chk("dp_idle_zero", 64'({dp_sign_A, dp_sign_B, dp_exp_A, dp_exp_B, dp_mantis_A}), 64'd0);
    end
    if (rv_e) begin
      chk("res_data", 64'(res_data), 64'(cur.dres));
      chk("res_inexact", 64'(res_inexact), 64'(cur.dloss));
      chk("res_src", 64'(res_src), 64'(cur.src));
      chk("res_tag", 64'(res_tag), 64'(cur.tag));
    end

    if (rv_e && rr) begin
      active = 1'b0;
    end else if (!was_active && (pend[0] || pend[1])) begin
      cur.src   = g;
      cur.a     = pa[g];
      cur.b     = pb[g];
      cur.sub   = psub[g];
      cur.tag   = ptag[g];
      cur.dres  = forced_en ? forced_res  : $urandom;
      cur.dloss = forced_en ? forced_loss : 1'($urandom);
      active  = 1'b1;
      acc     = cyc;
      last_g  = g;
      pend[g] = 1'b0;
      have_op = 1'b1;
      grants.push_back(int'(g));
    end
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    //        src a             b             sub tag    dres          loss sa sb ea     eb     ma            mb
    tbl[0] = '{1'b0, 32'h3F800000, 32'h40000000, 1'b0, 4'h5, 32'h40400000, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h80, 26'h2000000, 26'h2000000};
    tbl[1] = '{1'b1, 32'h40400000, 32'h3F800000, 1'b1, 4'h3, 32'h40000000, 1'b0, 1'b0, 1'b1, 8'h80, 8'h7F, 26'h3000000, 26'h2000000};
    tbl[2] = '{1'b0, 32'h3F800000, 32'h00000000, 1'b0, 4'h9, 32'h3F800000, 1'b1, 1'b0, 1'b0, 8'h7F, 8'h00, 26'h2000000, 26'h0000000};
    tbl[3] = '{1'b1, 32'h7F800000, 32'hFF800000, 1'b1, 4'hA, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 26'h2000000, 26'h2000000};
    tbl[4] = '{1'b0, 32'h80000003, 32'h00000001, 1'b0, 4'hF, 32'h12345678, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 26'h000000C, 26'h0000004};

    rst_n = 1'b1;
    rr = 1'b1; rr_rand = 1'b0; auto_pct = 0; forced_en = 1'b0;
    forced_res = '0; forced_loss = 1'b0;
    res_ready = 1'b1; dp_result = '0; dp_loss = 1'b0;
    req0_valid = 1'b1; req0_sub = 1'b0; req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_valid = 1'b1; req1_sub = 1'b0; req1_a = '0; req1_b = '0; req1_tag = '0;
    #2;
    do_reset();

    // Directed vectors from the table
    forced_en = 1'b1;
    for (int v = 0; v < 5; v++) begin
      pend[tbl[v].src] = 1'b1;
      pa[tbl[v].src]   = tbl[v].a;
      pb[tbl[v].src]   = tbl[v].b;
      psub[tbl[v].src] = tbl[v].sub;
      ptag[tbl[v].src] = tbl[v].tag;
      forced_res  = tbl[v].dres;
      forced_loss = tbl[v].dloss;
      n = 0;
      do begin step(); n++; end while (!(active && (cyc - 1 == acc + 1)) && n < 20);
      chk("vec_start_seen", 64'(n < 20), 64'd1);
      chk("vec_dp_start", 64'(dp_start), 64'd1);
      chk("vec_signs", 64'({dp_sign_A, dp_sign_B}), 64'({tbl[v].sa, tbl[v].sb}));
      chk("vec_exp_A", 64'(dp_exp_A), 64'(tbl[v].ea));
      chk("vec_exp_B", 64'(dp_exp_B), 64'(tbl[v].eb));
      chk("vec_mantis_A", 64'(dp_mantis_A), 64'(tbl[v].ma));
      chk("vec_mantis_B", 64'(dp_mantis_B), 64'(tbl[v].mb));
      repeat (L) step();
      chk("vec_res_valid", 64'(res_valid), 64'd1);
      chk("vec_res", 64'({res_data, res_inexact}), 64'({tbl[v].dres, tbl[v].dloss}));
      chk("vec_src_tag", 64'({res_src, res_tag}), 64'({tbl[v].src, tbl[v].tag}));
      n = 0;
      while (active && n < 20) begin step(); n++; end
      chk("vec_done", 64'(active), 64'd0);
    end
    forced_en = 1'b0;

    // Both requesters valid continuously after reset: strict alternation from req0
    do_reset();
    auto_pct = 100;
    base = grants.size();
    n = 0;
    while (grants.size() < base + 4 && n < 60) begin step(); n++; end
    chk("tie_count", 64'(grants.size() >= base + 4), 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (grants.size() > base + i) chk("tie_order", 64'(grants[base + i]), 64'(i % 2));
    end

    // Backpressure: result held in DONE for 10 cycles
    n = 0;
    while (!(active && (cyc - 1 >= acc + int'(L) + 1)) && n < 40) begin
      rr = 1'b0; step(); n++;
    end
    rr = 1'b0;
    repeat (10) step();
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_ready", 64'({req0_ready, req1_ready}), 64'd0);
    chk("bp_valid", 64'(res_valid), 64'd1);
    rr = 1'b1;
    step();
    step();
    chk("bp_idle", 64'(busy), 64'd0);

    // Reset in the middle of ISSUE, then a fresh request with full latency
    auto_pct = 0;
    n = 0;
    while (active && n < 20) begin step(); n++; end
    pend[0] = 1'b0; pend[1] = 1'b0;
    step();
    pend[0] = 1'b1; pa[0] = 32'h3F800000; pb[0] = 32'h40000000; psub[0] = 1'b0; ptag[0] = 4'h7;
    n = 0;
    do begin step(); n++; end while (!(active && (cyc - 1 == acc + 2)) && n < 20);
    chk("mid_reached", 64'(busy), 64'd1);
    do_reset();
    pend[1] = 1'b1; pa[1] = 32'h40400000; pb[1] = 32'h3F800000; psub[1] = 1'b1; ptag[1] = 4'h2;
    n = 0;
    do begin step(); n++; end while (active && n < 20);
    chk("post_reset_done", 64'(active), 64'd0);

    // Randomized traffic with random backpressure
    auto_pct = 40;
    rr_rand = 1'b1;
    repeat (1500) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_scheduler.md
# fp_add_scheduler

Sequencing and arbitration controller for the shared floating-point add datapath (preadder → adder → normalizer). It accepts add/subtract requests from two requesters, grants one at a time round-robin, unpacks the winning operands into the sign/exponent/extended-mantissa form the preadder consumes, and holds them stable for a fixed datapath latency. It then captures the packed result and loss flag and returns them with a source ID and tag through a valid/ready handshake.

## Interface

Parameters:
- EXP_SIZE, default 8: exponent field width.
- MANTIS_SIZE, default 23: stored fraction width. Operand width W = 1+EXP_SIZE+MANTIS_SIZE.
- DP_LATENCY, default 2: cycles the datapath needs from stable inputs to a valid dp_result. Legal range 1..15.
- TAG_WIDTH, default 4: width of the opaque request tag.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  request N (N=0,1) presents operands.
- reqN_ready  out  1  request N accepted this cycle when valid&ready.
- reqN_sub  in  1  1 = A−B, 0 = A+B.
- reqN_a, reqN_b  in  W  packed operands {sign, exp, frac}.
- reqN_tag  in  TAG_WIDTH  returned unchanged with the result.
- dp_start  out  1  one-cycle strobe in the first cycle new operands are driven.
- dp_sign_A, dp_sign_B  out  1  operand signs; dp_sign_B is already inverted for subtract.
- dp_exp_A, dp_exp_B  out  EXP_SIZE  exponent fields.
- dp_mantis_A, dp_mantis_B  out  MANTIS_SIZE+3  {hidden, frac, 2'b00}, where hidden = OR of the exponent field.
- dp_result  in  W  packed datapath result.
- dp_loss  in  1  preadder shift-out loss flag.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  W  captured dp_result.
- res_src  out  1  requester index that issued the operation.
- res_tag  out  TAG_WIDTH  tag of that request.
- res_inexact  out  1  captured dp_loss.
- busy  out  1  high in any state other than IDLE.

## Operation

- FSM states:
  - IDLE: arbitration enabled.
  - ISSUE: operands are driven to the datapath.
  - DONE: result is held for the consumer.
- Arbitration runs in IDLE only:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester that was not last granted is granted.
  - last_grant updates on every accept. Its reset value is 1, so req0 wins the first tie.
- reqN_ready = (state==IDLE) & grant==N. It is combinational from reqN_valid and state, and at most one ready is high at a time. No ready is asserted outside IDLE.
- Accept (valid&ready at the edge), all in the same edge:
  - Unpack the operands into the dp_* registers; dp_sign_B = b.sign ^ sub.
  - Latch src and tag.
  - Load the counter with DP_LATENCY.
  - Go to ISSUE.
- ISSUE:
  - dp_* outputs are held constant.
  - dp_start is high only in the first ISSUE cycle.
  - The counter decrements each cycle.
  - On the edge where the counter equals 1, capture dp_result and dp_loss into res_data and res_inexact, then go to DONE.
- DONE:
  - res_valid=1; res_data, res_src, res_tag and res_inexact are stable until the handshake.
  - On res_valid&res_ready, go to IDLE.
  - A request may be accepted no earlier than the cycle after return to IDLE.
- Unpacking:
  - Exponent 0 yields hidden=0, so a zero operand gives mantis 0.
  - Special values (Inf/NaN) are passed through unmodified. Special-value handling belongs to the datapath.
- Requests that are valid but not granted must be held by the requester. The controller never drops or reorders them.

## Timing

- Reset (asynchronous, takes effect immediately on rst_n=0):
  - state=IDLE, last_grant=1, counter=0.
  - All outputs 0: dp_*, dp_start, res_*, busy, reqN_ready. Exception: reqN_ready may rise combinationally once rst_n=1 and in IDLE.
- Reset mid-operation aborts the operation; no result is produced for it.
- Latency:
  - Accept at edge k.
  - dp_* valid and dp_start high during cycle k+1.
  - dp_result sampled at edge k+DP_LATENCY.
  - res_valid high from cycle k+DP_LATENCY+1.
- Throughput with res_ready held high: one operation per DP_LATENCY+2 cycles.
- Backpressure: res_ready=0 holds DONE indefinitely, and dp_* keep their last values.
- DP_LATENCY=1: ISSUE lasts exactly one cycle; dp_start and the result capture fall in that same cycle.

## Test plan

- Single add, DP_LATENCY=2: req0 a=0x3F800000, b=0x40000000, sub=0, tag=5, accepted at edge 0 → cycle 1 has dp_start=1, dp_exp_A=127, dp_exp_B=128, dp_mantis_A=0x2000000; with the model returning 0x40400000, res_valid=1 from cycle 3, res_data=0x40400000, res_src=0, res_tag=5.
- Subtract: req1 a=0x40400000, b=0x3F800000, sub=1 → dp_sign_A=0, dp_sign_B=1; res_src=1.
- Tie: both valid continuously after reset → grants in the order req0, req1, req0, req1; never both ready in one cycle; the idle requester's operands are never captured.
- Backpressure: res_ready=0 for 10 cycles in DONE → res_* stable, busy=1, both ready=0; res_ready=1 → IDLE next cycle.
- Zero operand: b=0x00000000 → dp_exp_B=0, dp_mantis_B=0; dp_loss=1 from the model → res_inexact=1.
- Reset mid-ISSUE: rst_n=0 during cycle 2 → all outputs 0 immediately; after release, a new request gets full latency and res_valid appears only for the new request.
